// File: rtl/auth_requester.sv
// Initiator side of the ATM account-authentication interface: keypad entry,
// one-cycle authenticator request, per-account lockout and session control.
module auth_requester #(
  parameter int MAX_TRIES      = 3,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int PIN_DIGITS     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  output logic [3:0]  acc_num,
  output logic [15:0] pin,
  output logic        auth_req,
  input  logic        acc_found_stat,
  input  logic        acc_auth_stat,
  input  logic [3:0]  acc_index_in,
  output logic        session_active,
  output logic [3:0]  acc_index_out,
  output logic        error_valid,
  output logic [2:0]  error_code
);

  typedef enum logic [1:0] {
    S_ACC     = 2'd0,
    S_PIN     = 2'd1,
    S_REQ     = 2'd2,
    S_SESSION = 2'd3
  } state_t;

  localparam logic [3:0] KEY_ENTER  = 4'hA;
  localparam logic [3:0] KEY_CLEAR  = 4'hB;
  localparam logic [3:0] KEY_CANCEL = 4'hC;

  localparam logic [2:0] E_BAD_ACC   = 3'd1;
  localparam logic [2:0] E_LOCKED    = 3'd2;
  localparam logic [2:0] E_SHORT_PIN = 3'd3;
  localparam logic [2:0] E_NOT_FOUND = 3'd4;
  localparam logic [2:0] E_BAD_PIN   = 3'd5;
  localparam logic [2:0] E_TIMEOUT   = 3'd6;

  localparam logic [1:0] MAX_TRIES_W  = 2'(MAX_TRIES);
  localparam logic [2:0] PIN_DIGITS_W = 3'(PIN_DIGITS);
  localparam int         TW           = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  state_t        state_r;
  logic [1:0]    acc_digits_r;
  logic [2:0]    pin_digits_r;
  logic [1:0]    fail_cnt_r [16];
  logic [TW-1:0] tmo_cnt_r;

  logic          is_digit_s;
  logic [7:0]    acc_calc_s;
  logic [15:0]   pin_calc_s;
  logic [1:0]    fail_cur_s;
  logic [1:0]    fail_inc_s;
  logic          tmo_run_s;
  logic          tmo_hit_s;

  // Next-digit arithmetic, saturating fail increment and idle-timeout detection
  always_comb begin
    is_digit_s = (key_code <= 4'd9);
    acc_calc_s = ({4'd0, acc_num} * 8'd10) + {4'd0, key_code};
    pin_calc_s = (pin * 16'd10) + {12'd0, key_code};
    fail_cur_s = fail_cnt_r[acc_num];
    if (fail_cur_s == 2'd3) begin
      fail_inc_s = 2'd3;
    end else begin
      fail_inc_s = fail_cur_s + 2'd1;
    end
    case (state_r)
      S_ACC:     tmo_run_s = (acc_digits_r != 2'd0);
      S_PIN:     tmo_run_s = 1'b1;
      S_SESSION: tmo_run_s = 1'b1;
      default:   tmo_run_s = 1'b0;
    endcase
    // a key in the expiring cycle always wins over the timeout
    tmo_hit_s = tmo_run_s && !key_valid && (tmo_cnt_r == TMO_LAST);
  end

  // Request FSM with entry fields, fail table, idle counter and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= S_ACC;
      acc_num        <= 4'd0;
      pin            <= 16'd0;
      acc_digits_r   <= 2'd0;
      pin_digits_r   <= 3'd0;
      auth_req       <= 1'b0;
      session_active <= 1'b0;
      acc_index_out  <= 4'd0;
      error_valid    <= 1'b0;
      error_code     <= 3'd0;
      tmo_cnt_r      <= {TW{1'b0}};
      for (int i = 0; i < 16; i++) begin
        fail_cnt_r[i] <= 2'd0;
      end
    end else begin
      auth_req    <= 1'b0;
      error_valid <= 1'b0;

      if (key_valid || !tmo_run_s || tmo_hit_s) begin
        tmo_cnt_r <= {TW{1'b0}};
      end else begin
        tmo_cnt_r <= tmo_cnt_r + TW'(1);
      end

      if (tmo_hit_s) begin
        error_valid    <= 1'b1;
        error_code     <= E_TIMEOUT;
        state_r        <= S_ACC;
        session_active <= 1'b0;
        acc_num        <= 4'd0;
        acc_digits_r   <= 2'd0;
        pin            <= 16'd0;
        pin_digits_r   <= 3'd0;
      end else begin
        case (state_r)
          S_ACC: begin
            if (key_valid) begin
              if (is_digit_s) begin
                if (acc_digits_r != 2'd2) begin
                  if (acc_calc_s > 8'd15) begin
                    error_valid  <= 1'b1;
                    error_code   <= E_BAD_ACC;
                    acc_num      <= 4'd0;
                    acc_digits_r <= 2'd0;
                  end else begin
                    acc_num      <= acc_calc_s[3:0];
                    acc_digits_r <= acc_digits_r + 2'd1;
                  end
                end
              end else if (key_code == KEY_ENTER) begin
                if ((acc_digits_r == 2'd0) || (acc_num == 4'd0)) begin
                  error_valid  <= 1'b1;
                  error_code   <= E_BAD_ACC;
                  acc_num      <= 4'd0;
                  acc_digits_r <= 2'd0;
                end else if (fail_cur_s == MAX_TRIES_W) begin
                  error_valid  <= 1'b1;
                  error_code   <= E_LOCKED;
                  acc_num      <= 4'd0;
                  acc_digits_r <= 2'd0;
                end else begin
                  state_r      <= S_PIN;
                  pin          <= 16'd0;
                  pin_digits_r <= 3'd0;
                end
              end else if ((key_code == KEY_CLEAR) || (key_code == KEY_CANCEL)) begin
                acc_num      <= 4'd0;
                acc_digits_r <= 2'd0;
                pin          <= 16'd0;
                pin_digits_r <= 3'd0;
              end
            end
          end

          S_PIN: begin
            if (key_valid) begin
              if (is_digit_s) begin
                if (pin_digits_r < PIN_DIGITS_W) begin
                  pin          <= pin_calc_s;
                  pin_digits_r <= pin_digits_r + 3'd1;
                end
              end else if (key_code == KEY_ENTER) begin
                if (pin_digits_r != PIN_DIGITS_W) begin
                  error_valid  <= 1'b1;
                  error_code   <= E_SHORT_PIN;
                  pin          <= 16'd0;
                  pin_digits_r <= 3'd0;
                end else begin
                  state_r  <= S_REQ;
                  auth_req <= 1'b1;
                end
              end else if (key_code == KEY_CLEAR) begin
                pin          <= 16'd0;
                pin_digits_r <= 3'd0;
              end else if (key_code == KEY_CANCEL) begin
                state_r      <= S_ACC;
                acc_num      <= 4'd0;
                acc_digits_r <= 2'd0;
                pin          <= 16'd0;
                pin_digits_r <= 3'd0;
              end
            end
          end

          // authenticator result is taken at the edge that closes the request cycle
          S_REQ: begin
            if (!acc_found_stat) begin
              error_valid  <= 1'b1;
              error_code   <= E_NOT_FOUND;
              state_r      <= S_ACC;
              acc_num      <= 4'd0;
              acc_digits_r <= 2'd0;
              pin          <= 16'd0;
              pin_digits_r <= 3'd0;
            end else if (acc_auth_stat) begin
              fail_cnt_r[acc_num] <= 2'd0;
              acc_index_out       <= acc_index_in;
              session_active      <= 1'b1;
              state_r             <= S_SESSION;
            end else begin
              fail_cnt_r[acc_num] <= fail_inc_s;
              error_valid         <= 1'b1;
              pin                 <= 16'd0;
              pin_digits_r        <= 3'd0;
              if (fail_inc_s == MAX_TRIES_W) begin
                error_code   <= E_LOCKED;
                state_r      <= S_ACC;
                acc_num      <= 4'd0;
                acc_digits_r <= 2'd0;
              end else begin
                error_code <= E_BAD_PIN;
                state_r    <= S_PIN;
              end
            end
          end

          S_SESSION: begin
            if (key_valid && (key_code == KEY_CANCEL)) begin
              session_active <= 1'b0;
              state_r        <= S_ACC;
              acc_num        <= 4'd0;
              acc_digits_r   <= 2'd0;
              pin            <= 16'd0;
              pin_digits_r   <= 3'd0;
            end
          end

          default: begin
            state_r        <= S_ACC;
            session_active <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_auth_requester.sv
// Self-checking bench for auth_requester: directed scenarios plus a randomized
// run checked against a digit-queue reference model.
module tb_auth_requester;

  localparam int T  = 10;
  localparam int MT = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        key_valid = 1'b0;
  logic [3:0]  key_code = 4'd0;
  logic        acc_found_stat = 1'b0;
  logic        acc_auth_stat = 1'b0;
  logic [3:0]  acc_index_in = 4'd0;
  logic [3:0]  acc_num;
  logic [15:0] pin;
  logic        auth_req;
  logic        session_active;
  logic [3:0]  acc_index_out;
  logic        error_valid;
  logic [2:0]  error_code;

  int checks = 0;
  int failures = 0;

  auth_requester #(.MAX_TRIES(MT), .TIMEOUT_CYCLES(T), .PIN_DIGITS(4)) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
    .acc_num(acc_num), .pin(pin), .auth_req(auth_req),
    .acc_found_stat(acc_found_stat), .acc_auth_stat(acc_auth_stat),
    .acc_index_in(acc_index_in), .session_active(session_active),
    .acc_index_out(acc_index_out), .error_valid(error_valid), .error_code(error_code)
  );

  always #5 clk = ~clk;

  // Reference model: entry fields kept as typed digit lists; phase 0 account,
  // 1 pin, 2 waiting on authenticator, 3 session.
  int m_ph;
  int m_acc_q[$];
  int m_pin_q[$];
  int m_fail[16];
  int m_idle;
  int m_ec;
  int m_idx;
  bit m_areq, m_sess, m_ev;

  function automatic int fold(input int q[$]);
    int v = 0;
    foreach (q[i]) v = v * 10 + q[i];
    return v;
  endfunction

  task automatic model_reset();
    m_ph = 0; m_acc_q.delete(); m_pin_q.delete(); m_idle = 0;
    m_ec = 0; m_idx = 0; m_areq = 0; m_sess = 0; m_ev = 0;
    for (int i = 0; i < 16; i++) m_fail[i] = 0;
  endtask

  task automatic model_go_acc();
    m_acc_q.delete(); m_pin_q.delete(); m_ph = 0; m_sess = 0;
  endtask

  task automatic model_err(input int c);
    m_ev = 1; m_ec = c;
  endtask

  task automatic model_step(input bit kv, input int kc, input bit f, input bit a, input int ix);
    int prev = m_ph;
    int v;
    bit running;
    m_ev = 0; m_areq = 0;
    running = (m_ph == 1) || (m_ph == 3) || (m_ph == 0 && m_acc_q.size() > 0);
    if (kv) m_idle = 0;
    else if (running) m_idle++;
    else m_idle = 0;
    if (m_idle == T) begin
      m_idle = 0; model_err(6); model_go_acc();
    end else if (m_ph == 0) begin
      if (kv && kc <= 9) begin
        if (m_acc_q.size() < 2) begin
          v = fold(m_acc_q) * 10 + kc;
          if (v > 15) begin model_err(1); m_acc_q.delete(); end
          else m_acc_q.push_back(kc);
        end
      end else if (kv && kc == 10) begin
        v = fold(m_acc_q);
        if (m_acc_q.size() == 0 || v == 0) begin model_err(1); m_acc_q.delete(); end
        else if (m_fail[v] >= MT) begin model_err(2); m_acc_q.delete(); end
        else begin m_ph = 1; m_pin_q.delete(); end
      end else if (kv && (kc == 11 || kc == 12)) begin
        m_acc_q.delete(); m_pin_q.delete();
      end
    end else if (m_ph == 1) begin
      if (kv && kc <= 9) begin
        if (m_pin_q.size() < 4) m_pin_q.push_back(kc);
      end else if (kv && kc == 10) begin
        if (m_pin_q.size() < 4) begin model_err(3); m_pin_q.delete(); end
        else begin m_ph = 2; m_areq = 1; end
      end else if (kv && kc == 11) begin
        m_pin_q.delete();
      end else if (kv && kc == 12) begin
        model_go_acc();
      end
    end else if (m_ph == 2) begin
      v = fold(m_acc_q);
      if (!f) begin model_err(4); model_go_acc(); end
      else if (a) begin m_fail[v] = 0; m_idx = ix; m_sess = 1; m_ph = 3; end
      else begin
        if (m_fail[v] < 3) m_fail[v]++;
        if (m_fail[v] >= MT) begin model_err(2); model_go_acc(); end
        else begin model_err(5); m_pin_q.delete(); m_ph = 1; end
      end
    end else begin
      if (kv && kc == 12) model_go_acc();
    end
    if (m_ph != prev) m_idle = 0;
  endtask

  task automatic tick(input bit kv, input logic [3:0] kc);
    key_valid = kv; key_code = kc;
    @(posedge clk);
    model_step(kv, int'(kc), acc_found_stat, acc_auth_stat, int'(acc_index_in));
    #1;
    key_valid = 1'b0;
  endtask

  // '0'-'9' digits, E enter, C clear, X cancel, anything else an idle cycle
  task automatic keys(input string s);
    for (int i = 0; i < s.len(); i++) begin
      byte c;
      c = s[i];
      if (c >= 8'h30 && c <= 8'h39) tick(1'b1, 4'(c - 8'h30));
      else if (c == 8'h45) tick(1'b1, 4'hA);
      else if (c == 8'h43) tick(1'b1, 4'hB);
      else if (c == 8'h58) tick(1'b1, 4'hC);
      else tick(1'b0, 4'h0);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    model_reset();
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({acc_num, pin, auth_req, session_active, acc_index_out, error_valid, error_code} !== 31'd0) begin
      failures++;
      $display("FAIL reset: acc=%0d pin=%0d req=%b sess=%b idx=%0d ev=%b ec=%0d, all must be 0",
               acc_num, pin, auth_req, session_active, acc_index_out, error_valid, error_code);
    end
  endtask

  task automatic test_auth_ok();
    acc_found_stat = 1'b1; acc_auth_stat = 1'b1; acc_index_in = 4'd0;
    keys("1E1234E");
    checks++;
    if (auth_req !== 1'b1 || acc_num !== 4'd1 || pin !== 16'd1234) begin
      failures++;
      $display("FAIL auth_ok_req: req=%b acc=%0d pin=%0d, need 1/1/1234", auth_req, acc_num, pin);
    end
    keys(".");
    checks++;
    if (auth_req !== 1'b0 || session_active !== 1'b1 || acc_index_out !== 4'd0 || error_valid !== 1'b0) begin
      failures++;
      $display("FAIL auth_ok_session: req=%b sess=%b idx=%0d ev=%b, need 0/1/0/0",
               auth_req, session_active, acc_index_out, error_valid);
    end
    keys("5E");
    checks++;
    if (session_active !== 1'b1) begin
      failures++;
      $display("FAIL session_ignores_keys: sess=%b, need 1", session_active);
    end
    keys("X");
    checks++;
    if (session_active !== 1'b0 || acc_num !== 4'd0) begin
      failures++;
      $display("FAIL cancel_session: sess=%b acc=%0d, need 0/0", session_active, acc_num);
    end
  endtask

  task automatic test_lockout();
    int exp_ec[3] = '{5, 5, 2};
    do_reset();
    acc_found_stat = 1'b1; acc_auth_stat = 1'b0;
    keys("2E");
    for (int k = 0; k < 3; k++) begin
      keys("9999E.");
      checks++;
      if (error_valid !== 1'b1 || error_code !== 3'(exp_ec[k])) begin
        failures++;
        $display("FAIL wrong_pin_%0d: ev=%b ec=%0d, need 1/%0d", k, error_valid, error_code, exp_ec[k]);
      end
    end
    keys("2E");
    checks++;
    if (error_valid !== 1'b1 || error_code !== 3'd2 || acc_num !== 4'd0) begin
      failures++;
      $display("FAIL locked_reentry: ev=%b ec=%0d acc=%0d, need 1/2/0", error_valid, error_code, acc_num);
    end
    do_reset();
    keys("2E");
    checks++;
    if (error_valid !== 1'b0) begin
      failures++;
      $display("FAIL unlock_after_rst: ev=%b ec=%0d, need ev 0", error_valid, error_code);
    end
    keys("1234E");
    checks++;
    if (auth_req !== 1'b1 || acc_num !== 4'd2) begin
      failures++;
      $display("FAIL unlock_req: req=%b acc=%0d, need 1/2", auth_req, acc_num);
    end
    do_reset();
    checks++;
    if (auth_req !== 1'b0 || acc_num !== 4'd0 || pin !== 16'd0 || error_code !== 3'd0) begin
      failures++;
      $display("FAIL mid_req_reset: req=%b acc=%0d pin=%0d ec=%0d, need 0", auth_req, acc_num, pin, error_code);
    end
  endtask

  task automatic test_bad_acc();
    keys("17");
    checks++;
    if (error_valid !== 1'b1 || error_code !== 3'd1 || acc_num !== 4'd0) begin
      failures++;
      $display("FAIL bad_acc_17: ev=%b ec=%0d acc=%0d, need 1/1/0", error_valid, error_code, acc_num);
    end
    keys("E");
    checks++;
    if (error_valid !== 1'b1 || error_code !== 3'd1) begin
      failures++;
      $display("FAIL bad_acc_empty: ev=%b ec=%0d, need 1/1", error_valid, error_code);
    end
    keys("123");
    checks++;
    if (acc_num !== 4'd12 || error_valid !== 1'b0) begin
      failures++;
      $display("FAIL acc_two_digits: acc=%0d ev=%b, need 12/0", acc_num, error_valid);
    end
    keys("E");
    checks++;
    if (error_valid !== 1'b0 || acc_num !== 4'd12) begin
      failures++;
      $display("FAIL acc_12_enter: ev=%b acc=%0d, need 0/12", error_valid, acc_num);
    end
    keys("X");
  endtask

  task automatic test_short_pin();
    keys("1E123E");
    checks++;
    if (error_valid !== 1'b1 || error_code !== 3'd3 || pin !== 16'd0) begin
      failures++;
      $display("FAIL short_pin: ev=%b ec=%0d pin=%0d, need 1/3/0", error_valid, error_code, pin);
    end
    keys("56789");
    checks++;
    if (pin !== 16'd5678) begin
      failures++;
      $display("FAIL pin_extra_digit: pin=%0d, need 5678", pin);
    end
    keys("C");
    checks++;
    if (pin !== 16'd0 || acc_num !== 4'd1) begin
      failures++;
      $display("FAIL pin_clear: pin=%0d acc=%0d, need 0/1", pin, acc_num);
    end
    keys("X");
  endtask

  task automatic test_not_found();
    acc_found_stat = 1'b0; acc_auth_stat = 1'b1;
    keys("11E4321E");
    checks++;
    if (auth_req !== 1'b1 || acc_num !== 4'd11 || pin !== 16'd4321) begin
      failures++;
      $display("FAIL nf_req: req=%b acc=%0d pin=%0d, need 1/11/4321", auth_req, acc_num, pin);
    end
    keys(".");
    checks++;
    if (error_valid !== 1'b1 || error_code !== 3'd4 || acc_num !== 4'd0 || session_active !== 1'b0) begin
      failures++;
      $display("FAIL not_found: ev=%b ec=%0d acc=%0d sess=%b, need 1/4/0/0",
               error_valid, error_code, acc_num, session_active);
    end
  endtask

  task automatic test_timeout();
    int early = 0;
    keys("1E5");
    for (int i = 0; i < T - 1; i++) begin
      tick(1'b0, 4'd0);
      if (error_valid !== 1'b0) early++;
    end
    tick(1'b0, 4'd0);
    checks++;
    if (early != 0 || error_valid !== 1'b1 || error_code !== 3'd6 || acc_num !== 4'd0 || pin !== 16'd0) begin
      failures++;
      $display("FAIL pin_timeout: early=%0d ev=%b ec=%0d acc=%0d pin=%0d, need 0/1/6/0/0",
               early, error_valid, error_code, acc_num, pin);
    end
    keys("1E5");
    for (int i = 0; i < T - 1; i++) tick(1'b0, 4'd0);
    tick(1'b1, 4'd6);
    checks++;
    if (error_valid !== 1'b0 || pin !== 16'd56) begin
      failures++;
      $display("FAIL key_beats_timeout: ev=%b pin=%0d, need 0/56", error_valid, pin);
    end
    keys("X");
    acc_found_stat = 1'b1; acc_auth_stat = 1'b1; acc_index_in = 4'd7;
    keys("3E4321E.");
    checks++;
    if (session_active !== 1'b1 || acc_index_out !== 4'd7) begin
      failures++;
      $display("FAIL session_idx: sess=%b idx=%0d, need 1/7", session_active, acc_index_out);
    end
    for (int i = 0; i < T; i++) tick(1'b0, 4'd0);
    checks++;
    if (session_active !== 1'b0 || error_valid !== 1'b1 || error_code !== 3'd6) begin
      failures++;
      $display("FAIL session_timeout: sess=%b ev=%b ec=%0d, need 0/1/6", session_active, error_valid, error_code);
    end
  endtask

  task automatic test_random();
    int bad = 0;
    int burst = 0;
    logic [3:0] kc;
    bit kv;
    int r;
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      if (n == 2000) do_reset();
      acc_found_stat = ($urandom_range(0, 9) != 0);
      acc_auth_stat  = ($urandom_range(0, 1) == 1);
      acc_index_in   = 4'($urandom_range(0, 15));
      if (burst == 0 && $urandom_range(0, 39) == 0) burst = $urandom_range(8, 12);
      r = $urandom_range(0, 99);
      if (r < 60) kc = 4'($urandom_range(0, 9));
      else if (r < 78) kc = 4'hA;
      else if (r < 83) kc = 4'hB;
      else if (r < 86) kc = 4'hC;
      else kc = 4'($urandom_range(13, 15));
      kv = (burst == 0) && ($urandom_range(0, 9) < 7);
      if (burst > 0) burst--;
      tick(kv, kc);
      checks++;
      if (acc_num !== 4'(fold(m_acc_q)) || pin !== 16'(fold(m_pin_q)) || auth_req !== m_areq ||
          session_active !== m_sess || error_valid !== m_ev || error_code !== 3'(m_ec) ||
          (m_sess && acc_index_out !== 4'(m_idx))) begin
        failures++;
        bad++;
        if (bad <= 10)
          $display("FAIL random_%0d: acc=%0d/%0d pin=%0d/%0d req=%b/%b sess=%b/%b ev=%b/%b ec=%0d/%0d idx=%0d/%0d (got/need)",
                   n, acc_num, fold(m_acc_q), pin, fold(m_pin_q), auth_req, m_areq,
                   session_active, m_sess, error_valid, m_ev, error_code, m_ec, acc_index_out, m_idx);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    model_reset();
    test_reset();
    test_auth_ok();
    test_lockout();
    test_bad_acc();
    test_short_pin();
    test_not_found();
    test_timeout();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
